// File: rtl/trng_pkg.sv
// Shared state encoding and default configuration
// for the trng_8x7 sampler controller.
package trng_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WARMUP,
    COLLECT,
    FULL,
    FAIL
  } state_t;

  localparam int TRNG_WORD_WIDTH = 32;
  localparam int TRNG_WARMUP     = 256;
  localparam int TRNG_DECIM      = 4;
  localparam int TRNG_REP_LIMIT  = 32;

endpackage

// File: rtl/trng_rep_test.sv
// Repetition-count health test: flags a run of
// REP_LIMIT identical accepted samples.
module trng_rep_test
  import trng_pkg::*;
#(
  parameter int REP_LIMIT = TRNG_REP_LIMIT
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic sample,
  input  logic bit_val,
  output logic fail
);

  localparam int RW = $clog2(REP_LIMIT) + 1;

  logic [RW-1:0] run;
  logic [RW-1:0] run_next;
  logic          prev;

  // run == 0 means no sample seen since the last clear
  always_comb begin
    run_next = RW'(1);
    if (run != '0 && bit_val == prev)
      run_next = run + RW'(1);
  end

  assign fail = sample && (run_next == RW'(REP_LIMIT));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run  <= '0;
      prev <= 1'b0;
    end else if (clr) begin
      run  <= '0;
      prev <= 1'b0;
    end else if (sample) begin
      run  <= run_next;
      prev <= bit_val;
    end
  end

endmodule

// File: rtl/trng_sampler_ctrl.sv
// Warm-up, decimation, word packing and health
// checking for the trng_8x7 ring-oscillator TRNG.
module trng_sampler_ctrl
  import trng_pkg::*;
#(
  parameter int WORD_WIDTH    = TRNG_WORD_WIDTH,
  parameter int WARMUP_CYCLES = TRNG_WARMUP,
  parameter int DECIM         = TRNG_DECIM,
  parameter int REP_LIMIT     = TRNG_REP_LIMIT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  clear_fail,
  output logic                  trng_en,
  input  logic                  trng_out,
  output logic [WORD_WIDTH-1:0] data,
  output logic                  valid,
  input  logic                  ready,
  output logic                  health_fail,
  output logic                  busy
);

  localparam int WCW = $clog2(WARMUP_CYCLES) + 1;
  localparam int DCW = $clog2(DECIM) + 1;
  localparam int BCW = $clog2(WORD_WIDTH) + 1;

  state_t state;
  state_t state_next;

  logic [WCW-1:0]        wcnt;
  logic [DCW-1:0]        dcnt;
  logic [BCW-1:0]        bcnt;
  logic [WORD_WIDTH-1:0] shreg;
  logic [WORD_WIDTH-1:0] word;
  logic                  sample;
  logic                  word_done;
  logic                  fire;
  logic                  out_free;
  logic                  rep_fail;
  logic                  rep_clr;
  logic                  stay;

  assign fire      = valid && ready;
  assign out_free  = !valid || fire;
  assign sample    = (state == COLLECT) && enable
                  && (dcnt == DCW'(DECIM - 1));
  assign word_done = sample
                  && (bcnt == BCW'(WORD_WIDTH - 1));
  assign word      = {shreg[WORD_WIDTH-2:0], trng_out};
  assign rep_clr   = !(state == COLLECT || state == FULL);
  assign stay      = (state == COLLECT)
                  && (state_next == COLLECT);

  trng_rep_test #(
    .REP_LIMIT(REP_LIMIT)
  ) u_rep (
    .clk    (clk),
    .reset  (reset),
    .clr    (rep_clr),
    .sample (sample),
    .bit_val(trng_out),
    .fail   (rep_fail)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // disable wins over health failure and word completion
  always_comb begin
    state_next = state;
    trng_en    = 1'b0;
    busy       = 1'b1;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (enable) state_next = WARMUP;
      end
      WARMUP: begin
        trng_en = 1'b1;
        if (!enable)
          state_next = IDLE;
        else if (wcnt == WCW'(WARMUP_CYCLES - 1))
          state_next = COLLECT;
      end
      COLLECT: begin
        trng_en = 1'b1;
        if (!enable)
          state_next = IDLE;
        else if (rep_fail)
          state_next = FAIL;
        else if (word_done && !out_free)
          state_next = FULL;
      end
      FULL: begin
        trng_en = 1'b1;
        if (!enable)    state_next = IDLE;
        else if (fire)  state_next = COLLECT;
      end
      FAIL: begin
        if (clear_fail) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wcnt        <= '0;
      dcnt        <= '0;
      bcnt        <= '0;
      shreg       <= '0;
      data        <= '0;
      valid       <= 1'b0;
      health_fail <= 1'b0;
    end else begin
      if (state == WARMUP && state_next == WARMUP)
        wcnt <= wcnt + WCW'(1);
      else
        wcnt <= '0;

      if (!stay)
        dcnt <= '0;
      else if (dcnt == DCW'(DECIM - 1))
        dcnt <= '0;
      else
        dcnt <= dcnt + DCW'(1);

      if (!stay)
        bcnt <= '0;
      else if (sample)
        bcnt <= word_done ? '0 : bcnt + BCW'(1);

      // a stalled word waits in shreg while in FULL
      if (state_next == IDLE || state_next == WARMUP
          || state_next == FAIL)
        shreg <= '0;
      else if (sample)
        shreg <= word;

      if (state_next == IDLE || state_next == FAIL) begin
        valid <= 1'b0;
      end else if (state == FULL && fire) begin
        data  <= shreg;
        valid <= 1'b1;
      end else if (word_done && out_free) begin
        data  <= word;
        valid <= 1'b1;
      end else if (fire) begin
        valid <= 1'b0;
      end

      if (state == COLLECT && state_next == FAIL)
        health_fail <= 1'b1;
      else if ((state == IDLE || state == FAIL)
               && clear_fail)
        health_fail <= 1'b0;
    end
  end

endmodule

// File: tb/tb_trng_sampler_ctrl.sv
// Bench for trng_sampler_ctrl: word table, scoreboard
// and hand-written multi-cycle corner sequences.
module tb_trng_sampler_ctrl;
  import trng_pkg::*;

  localparam int W = 8;

  logic clk = 1'b0;
  logic reset;
  logic en1;
  logic en3;
  logic clear_fail;
  logic trng_out;
  logic ready;

  logic         tre1, v1, hf1, busy1;
  logic [W-1:0] d1;
  logic         tre3, v3, hf3, busy3;
  logic [W-1:0] d3;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q[$];

  typedef struct {
    logic [W-1:0] bits;
    logic [W-1:0] want;
  } vec_t;

  vec_t vecs[8];

  always #5 clk = ~clk;

  trng_sampler_ctrl #(
    .WORD_WIDTH(W), .WARMUP_CYCLES(4),
    .DECIM(1), .REP_LIMIT(6)
  ) dut1 (
    .clk(clk), .reset(reset), .enable(en1),
    .clear_fail(clear_fail), .trng_en(tre1),
    .trng_out(trng_out), .data(d1), .valid(v1),
    .ready(ready), .health_fail(hf1), .busy(busy1)
  );

  trng_sampler_ctrl #(
    .WORD_WIDTH(W), .WARMUP_CYCLES(4),
    .DECIM(3), .REP_LIMIT(6)
  ) dut3 (
    .clk(clk), .reset(reset), .enable(en3),
    .clear_fail(clear_fail), .trng_en(tre3),
    .trng_out(trng_out), .data(d3), .valid(v3),
    .ready(ready), .health_fail(hf3), .busy(busy3)
  );

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h",
               name, act, want);
    end
  endtask

  // consumes a word from the scoreboard whenever the
  // coming edge completes a handshake on dut1
  task automatic step();
    logic [W-1:0] e;
    if (v1 === 1'b1 && ready === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL word_extra: got %h, expected none",
                 d1);
      end else begin
        e = exp_q.pop_front();
        if (d1 !== e) begin
          errors++;
          $display("FAIL word_data: got %h, expected %h",
                   d1, e);
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic feed(input logic b);
    trng_out = b;
    step();
  endtask

  task automatic feed_word(input logic [W-1:0] w,
                           input logic push);
    if (push) exp_q.push_back(w);
    for (int i = W - 1; i >= 0; i--) feed(w[i]);
  endtask

  task automatic start_warm();
    en1 = 1'b1;
    step();
    check("warm_trng_en", tre1, 1'b1);
    step();
    step();
    step();
    check("warm_state", dut1.state, WARMUP);
    check("warm_no_valid", v1, 1'b0);
    step();
    check("collect_state", dut1.state, COLLECT);
  endtask

  initial begin
    vecs[0] = '{8'hB2, 8'hB2};
    vecs[1] = '{8'h4D, 8'h4D};
    vecs[2] = '{8'h5A, 8'h5A};
    vecs[3] = '{8'hA5, 8'hA5};
    vecs[4] = '{8'h3C, 8'h3C};
    vecs[5] = '{8'hC3, 8'hC3};
    vecs[6] = '{8'h96, 8'h96};
    vecs[7] = '{8'h69, 8'h69};

    reset = 1'b1;
    en1 = 1'b0;
    en3 = 1'b0;
    clear_fail = 1'b0;
    trng_out = 1'b0;
    ready = 1'b0;
    step();
    step();
    check("rst_trng_en", tre1, 1'b0);
    check("rst_valid", v1, 1'b0);
    check("rst_data", d1, 8'h00);
    check("rst_fail", hf1, 1'b0);
    check("rst_busy", busy1, 1'b0);
    reset = 1'b0;
    step();
    check("idle_busy", busy1, 1'b0);

    // asynchronous reset in the middle of warm-up
    en1 = 1'b1;
    step();
    step();
    check("mid_warm_busy", busy1, 1'b1);
    reset = 1'b1;
    #1;
    check("async_trng_en", tre1, 1'b0);
    check("async_busy", busy1, 1'b0);
    check("async_valid", v1, 1'b0);
    check("async_fail", hf1, 1'b0);
    en1 = 1'b0;
    step();
    reset = 1'b0;
    step();
    check("post_rst_state", dut1.state, IDLE);

    // back-to-back words, MSB first
    ready = 1'b1;
    start_warm();
    for (int v = 0; v < 8; v++) begin
      exp_q.push_back(vecs[v].want);
      for (int i = W - 1; i >= 0; i--)
        feed(vecs[v].bits[i]);
      check("valid_on_word", v1, 1'b1);
    end
    feed(~trng_out);
    check("table_drained", exp_q.size(), 0);
    check("valid_drop", v1, 1'b0);
    en1 = 1'b0;
    step();

    // backpressure across two completed words
    ready = 1'b0;
    start_warm();
    feed_word(8'hB2, 1'b1);
    check("bp_first_valid", v1, 1'b1);
    check("bp_first_data", d1, 8'hB2);
    feed_word(8'h4D, 1'b1);
    check("bp_full_state", dut1.state, FULL);
    feed(1'b0);
    feed(1'b1);
    check("bp_full_hold", dut1.state, FULL);
    check("bp_data_hold", d1, 8'hB2);
    ready = 1'b1;
    feed(1'b0);
    ready = 1'b0;
    check("bp_reload_valid", v1, 1'b1);
    check("bp_reload_data", d1, 8'h4D);
    check("bp_collect", dut1.state, COLLECT);
    ready = 1'b1;
    feed(1'b1);
    check("bp_valid_clear", v1, 1'b0);
    en1 = 1'b0;
    step();

    // health failure, recovery, and near miss
    start_warm();
    for (int i = 0; i < 5; i++) feed(1'b1);
    check("hf_five_ok", hf1, 1'b0);
    feed(1'b1);
    check("hf_latched", hf1, 1'b1);
    check("hf_valid", v1, 1'b0);
    check("hf_trng_en", tre1, 1'b0);
    check("hf_state", dut1.state, FAIL);
    feed(1'b0);
    check("hf_ignores_en", dut1.state, FAIL);
    clear_fail = 1'b1;
    feed(1'b0);
    clear_fail = 1'b0;
    check("hf_cleared", hf1, 1'b0);
    check("hf_idle", dut1.state, IDLE);
    start_warm();
    feed_word(8'hFA, 1'b1);
    check("hf_near_miss", hf1, 1'b0);
    feed(1'b1);
    for (int i = 0; i < 4; i++) feed(1'b1);
    trng_out = 1'b1;
    en1 = 1'b0;
    step();
    check("dis_over_fail", hf1, 1'b0);
    check("dis_over_fail_idle", busy1, 1'b0);

    // disable with a word pending and a partial word
    ready = 1'b0;
    start_warm();
    feed_word(8'h5A, 1'b0);
    check("dis_pending", v1, 1'b1);
    feed(1'b1);
    feed(1'b0);
    feed(1'b1);
    en1 = 1'b0;
    step();
    check("dis_valid", v1, 1'b0);
    check("dis_trng_en", tre1, 1'b0);
    check("dis_busy", busy1, 1'b0);
    ready = 1'b1;
    start_warm();
    feed_word(8'hC3, 1'b1);
    feed(1'b0);
    check("reen_drained", exp_q.size(), 0);
    en1 = 1'b0;
    step();

    // decimation by three on an alternating source
    en3 = 1'b1;
    step();
    check("dec_trng_en", tre3, 1'b1);
    for (int i = 0; i < 4; i++) step();
    for (int k = 0; k < 24; k++) begin
      trng_out = (k % 2 == 0);
      step();
      if (k == 22) check("dec_not_yet", v3, 1'b0);
    end
    check("dec_valid", v3, 1'b1);
    check("dec_data", d3, 8'hAA);
    check("dec_no_fail", hf3, 1'b0);
    en3 = 1'b0;
    step();

    check("final_queue", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/trng_sampler_ctrl.md
Name: trng_sampler_ctrl

Overview:
Sequencer for the trng_8x7 ring-oscillator TRNG.
- Enables the oscillators and waits a fixed warm-up time.
- Decimates the trng_out bit stream and packs it into words.
- Runs a repetition-count health test on every sample.
- Presents words on a valid/ready interface to the SoC peripheral bus wrapper.

Parameters:
WORD_WIDTH, 32, bits per output word (>=2)
WARMUP_CYCLES, 256, clk cycles after enable before the first sample (>=1)
DECIM, 4, clk cycles between accepted samples (>=1; 1 = every cycle)
REP_LIMIT, 32, consecutive identical samples that trip the health test (>=2)

Ports:
clk  in  1  system clock; also drives the TRNG sampling clock
reset  in  1  asynchronous, active-high reset
enable  in  1  software enable; level-sensitive
clear_fail  in  1  single-cycle pulse; clears a latched health failure
trng_en  out  1  drives trng_8x7.trng_en
trng_out  in  1  registered TRNG bit from trng_8x7
data  out  WORD_WIDTH  random word
valid  out  1  data holds an unconsumed word
ready  in  1  consumer accepts data when valid && ready
health_fail  out  1  sticky health-test failure flag
busy  out  1  state != IDLE

Behaviour:
- Reset values: all outputs 0. State = IDLE; all counters and the shift register are 0.
- State IDLE: trng_en=0.
  - enable=1 -> WARMUP.
  - clear_fail=1 -> health_fail <= 0.
- State WARMUP: trng_en=1. Counts WARMUP_CYCLES cycles (entry cycle counts as 1), then -> COLLECT. No samples are taken during WARMUP.
- State COLLECT: trng_en=1. The decimation counter counts 0..DECIM-1 and a sample is taken when it wraps.
  - The first sample is taken DECIM cycles after entering COLLECT.
  - Sample action: shreg <= {shreg[WORD_WIDTH-2:0], trng_out}; the first bit taken ends up as the MSB.
  - When the WORD_WIDTH-th bit is taken:
    - If the output register is free (valid=0, or valid&&ready in the same cycle): data <= completed word; valid <= 1; the bit counter restarts.
    - Otherwise -> FULL, holding the completed word in shreg.
- State FULL: trng_en stays 1. Decimation and health counters are frozen.
  - On valid&&ready: data <= shreg, valid stays 1, -> COLLECT. The bit counter and decimation counter restart at 0.
- Output handshake: valid&&ready with no new load -> valid <= 0 next cycle. data is stable while valid=1 and ready=0.
- Health test: applied only to accepted samples.
  - Run counter starts at 1 on the first sample after entering COLLECT.
  - Run counter increments when a sample equals the previous sample, else resets to 1.
  - Run counter reaches REP_LIMIT -> health_fail <= 1, valid <= 0, shreg cleared, -> FAIL.
  - The failing sample is never output, and a word completing in the same cycle is discarded.
- State FAIL: trng_en=0. health_fail stays 1.
  - clear_fail=1 -> health_fail <= 0, -> IDLE.
  - The enable level is ignored in FAIL. After clear, if enable is still 1, WARMUP starts the following cycle.
- enable=0 in WARMUP/COLLECT/FULL -> IDLE next cycle.
  - trng_en drops on that edge.
  - valid <= 0 and any pending word is discarded.
  - shreg, bit, decimation and run counters are cleared.
  - health_fail is unaffected.
- Simultaneous events:
  - clear_fail outside IDLE/FAIL is ignored.
  - enable=0 takes priority over word completion and over health failure (no fail latched).
- Reset mid-operation returns to reset values asynchronously; trng_en deasserts immediately.
- Counter widths: $clog2 of each limit, plus 1 where needed, so the terminal count is representable. No wrap-around beyond the terminal count.

Decomposition:
- Package trng_pkg holds:
  - state enum: IDLE, WARMUP, COLLECT, FULL, FAIL
  - default localparams: TRNG_WORD_WIDTH=32, TRNG_WARMUP=256, TRNG_DECIM=4, TRNG_REP_LIMIT=32
- One natural sub-module: trng_rep_test (run counter, previous-bit register, fail output), reused by other TRNG configurations.
- The shifter and handshake stay in the top.

Test Plan (WORD_WIDTH=8, WARMUP_CYCLES=4, DECIM=1, REP_LIMIT=6; trng_8x7 replaced by a scripted bit source):
- Reset: reset=1 mid-WARMUP -> trng_en, valid, busy, health_fail = 0 immediately; after release, state = IDLE.
- Word order: enable=1, source 1,0,1,1,0,0,1,0 after warm-up, ready=1 -> trng_en=1 from cycle 1, first sample at cycle 6, valid=1 with data=8'hB2.
- Backpressure: ready=0 across two completed words 8'hB2, 8'h4D ->
  - data holds 8'hB2 and state is FULL;
  - ready pulse -> data=8'h4D, valid stays 1;
  - next ready -> valid=0.
- Health failure: six consecutive 1s -> health_fail=1, valid=0, trng_en=0. clear_fail pulse with enable=1 -> IDLE, then WARMUP on the following cycle. Five consecutive 1s then a 0 -> no fail.
- Disable: enable=0 with valid=1 and a partial word -> next cycle valid=0, trng_en=0, busy=0. Re-enable -> full WARMUP repeated before sampling.
- Decimation: DECIM=3, alternating source -> only every third source bit is captured; the run counter never reaches REP_LIMIT.
